// File: rtl/riscv_pkg.sv
// Shared fetch-side definitions: datapath width, PC stride, fetch FSM encoding.
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic [0:0] {
    StFetch = 1'b0,
    StDrain = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Registered instruction FIFO holding {pc, instr} entries; reads as zero when empty.
module fetch_fifo import riscv_pkg::*; #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 2 * XLEN
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PtrW-1:0]  rd_ptr, wr_ptr;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CntW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LastPtr) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == LastPtr) ? '0 : rd_ptr + 1'b1;
      count <= count + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch unit: owns the PC, issues in-order word reads and buffers responses for decode.
module instruction_fetch import riscv_pkg::*; #(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);

  fetch_state_e    state;
  logic [XLEN-1:0] pc;
  logic [CntW-1:0] outstanding, discard, out_next;
  logic [XLEN-1:0] rsp_pc [DEPTH];
  logic [PtrW-1:0] rsp_wr, rsp_rd;

  logic [CntW-1:0]   fifo_count;
  logic              fifo_empty, unused_fifo_full;
  logic [2*XLEN-1:0] fifo_head;
  logic [1:0]        unused_redirect_lsb;
  logic [CntW:0]     occupancy;
  logic              accept, resp, push, pop;

  assign unused_redirect_lsb = redirect_pc[1:0];

  // Buffered plus in-flight words never exceed DEPTH, so every response has a FIFO slot.
  assign occupancy = {1'b0, fifo_count} + {1'b0, outstanding};
  assign imem_req  = !reset && (state == StFetch) && (occupancy < (CntW + 1)'(DEPTH));
  assign imem_addr = pc;
  assign accept    = imem_req && imem_ready;
  assign resp      = imem_rvalid && (outstanding != '0);
  assign push      = resp && (discard == '0) && !redirect;
  assign pop       = instr_valid && instr_ready;
  assign out_next  = outstanding + CntW'(accept) - CntW'(resp);

  assign instr_valid = !fifo_empty;
  assign instr       = fifo_head[XLEN-1:0];
  assign instr_pc    = fifo_head[2*XLEN-1:XLEN];

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= StFetch;
      pc          <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      rsp_wr      <= '0;
      rsp_rd      <= '0;
    end else begin
      outstanding <= out_next;
      if (accept) rsp_wr <= (rsp_wr == LastPtr) ? '0 : rsp_wr + 1'b1;
      if (resp)   rsp_rd <= (rsp_rd == LastPtr) ? '0 : rsp_rd + 1'b1;
      if (redirect) begin
        // Everything still in flight after this cycle belongs to the old path.
        pc      <= {redirect_pc[XLEN-1:2], 2'b00};
        discard <= out_next;
        state   <= (out_next != '0) ? StDrain : StFetch;
      end else begin
        if (accept) pc <= pc + PC_STEP;
        if (resp && (discard != '0)) begin
          discard <= discard - 1'b1;
          if (discard == CntW'(1)) state <= StFetch;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) rsp_pc[rsp_wr] <= pc;
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2 * XLEN)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .din   ({rsp_pc[rsp_rd], imem_rdata}),
    .dout  (fifo_head),
    .count (fifo_count),
    .full  (unused_fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized bench for instruction_fetch against a queue-based model of the fetch rules.
module tb_instruction_fetch;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic reset, imem_req, imem_ready, imem_rvalid, redirect, instr_valid, instr_ready;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, instr, instr_pc;

  always #5 clk = ~clk;

  instruction_fetch #(
    .RESET_PC (RST_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Stimulus knobs
  int p_rdy = 100, p_dec = 100, p_redir = 0, lat = 1;
  bit force_redir = 0;
  logic [31:0] force_rpc;

  // Reference model: what the fetch unit should hold, as plain queues and counters
  int m_out, m_disc;
  bit m_drain;
  logic [31:0] m_pc;
  logic [31:0] m_fifo_pc[$], m_fifo_ins[$], m_inflight[$];

  // Memory: in-order responses, one per cycle, at least `lat` cycles after accept
  logic [31:0] mem_addr_q[$];
  int mem_due_q[$];
  int cyc = 0, last_due = 0;

  int since_rel, first_valid;
  logic [31:0] popped[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic model_reset();
    m_out = 0;
    m_disc = 0;
    m_drain = 0;
    m_pc = RST_PC;
    m_fifo_pc.delete();
    m_fifo_ins.delete();
    m_inflight.delete();
  endtask

  task automatic tick();
    bit acc, rsp, popv, exp_req, exp_valid;
    int new_out, due;
    logic [31:0] rpc;
    imem_ready  = ($urandom_range(99) < p_rdy);
    instr_ready = ($urandom_range(99) < p_dec);
    if (force_redir) begin
      redirect = 1'b1;
      redirect_pc = force_rpc;
      force_redir = 0;
    end else begin
      redirect = ($urandom_range(99) < p_redir);
      redirect_pc = $urandom;
    end
    if (mem_addr_q.size() > 0 && mem_due_q[0] <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata = mem_word(mem_addr_q.pop_front());
      void'(mem_due_q.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata = $urandom;
    end
    #1;
    exp_req = !reset && !m_drain && (m_fifo_pc.size() + m_out < DEPTH);
    exp_valid = (m_fifo_pc.size() > 0);
    check_eq("imem_req", imem_req, exp_req);
    check_eq("imem_addr", imem_addr, m_pc);
    check_eq("instr_valid", instr_valid, exp_valid);
    check_eq("instr", instr, exp_valid ? m_fifo_ins[0] : 32'h0);
    check_eq("instr_pc", instr_pc, exp_valid ? m_fifo_pc[0] : 32'h0);
    if (!reset && instr_valid && first_valid < 0) first_valid = since_rel;
    if (instr_valid && instr_ready) popped.push_back(instr_pc);

    acc = exp_req && imem_ready;
    if (acc) begin
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mem_addr_q.push_back(m_pc);
      mem_due_q.push_back(due);
    end

    if (reset) begin
      model_reset();
    end else begin
      rsp = imem_rvalid && (m_out > 0);
      popv = (m_fifo_pc.size() > 0) && instr_ready;
      new_out = m_out + int'(acc) - int'(rsp);
      if (acc) m_inflight.push_back(m_pc);
      rpc = 32'h0;
      if (rsp) rpc = m_inflight.pop_front();
      if (redirect) begin
        m_pc = redirect_pc & ~32'h3;
        m_fifo_pc.delete();
        m_fifo_ins.delete();
        m_disc = new_out;
        m_drain = (new_out > 0);
      end else begin
        if (acc) m_pc = m_pc + 32'd4;
        if (popv) begin
          void'(m_fifo_pc.pop_front());
          void'(m_fifo_ins.pop_front());
        end
        if (rsp) begin
          if (m_disc == 0) begin
            m_fifo_pc.push_back(rpc);
            m_fifo_ins.push_back(imem_rdata);
          end else begin
            m_disc--;
            if (m_disc == 0) m_drain = 0;
          end
        end
      end
      m_out = new_out;
    end
    @(posedge clk);
    cyc++;
    since_rel++;
    @(negedge clk);
  endtask

  task automatic redirect_to(input logic [31:0] target, input logic [31:0] exp_pc);
    lat = 3;
    p_rdy = 100;
    p_dec = 100;
    for (int i = 0; i < 20 && m_out != 2; i++) tick();
    force_redir = 1;
    force_rpc = target;
    tick();
    for (int i = 0; i < 30 && !instr_valid; i++) tick();
    check_eq("redir_valid", instr_valid, 1'b1);
    check_eq("redir_pc", instr_pc, exp_pc);
    check_eq("redir_instr", instr, mem_word(exp_pc));
  endtask

  initial begin
    logic [31:0] a0;
    reset = 1'b1;
    imem_ready = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata = '0;
    redirect = 1'b0;
    redirect_pc = '0;
    instr_ready = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    repeat (2) tick();

    // Start-up from RESET_PC near the top of the address space, wrapping through zero
    reset = 1'b0;
    since_rel = 0;
    first_valid = -1;
    popped.delete();
    repeat (12) tick();
    check_eq("first_valid_cycle", first_valid, 2);
    check_eq("stream_len_ok", popped.size() >= 4, 1'b1);
    if (popped.size() >= 4) begin
      check_eq("pc0", popped[0], 32'hFFFF_FFF8);
      check_eq("pc1", popped[1], 32'hFFFF_FFFC);
      check_eq("pc2", popped[2], 32'h0000_0000);
      check_eq("pc3", popped[3], 32'h0000_0004);
    end

    // Decode backpressure fills the FIFO and stops requests
    p_dec = 0;
    repeat (10) tick();
    check_eq("bp_req_off", imem_req, 1'b0);
    check_eq("bp_valid", instr_valid, 1'b1);
    p_dec = 100;
    repeat (10) tick();

    // Memory stall: address holds until the accepting edge
    for (int i = 0; i < 10 && !imem_req; i++) tick();
    check_eq("stall_req", imem_req, 1'b1);
    a0 = imem_addr;
    p_rdy = 0;
    repeat (3) tick();
    check_eq("stall_addr", imem_addr, a0);
    p_rdy = 100;
    tick();
    check_eq("stall_adv", imem_addr, a0 + 32'd4);

    // Redirect with fetches in flight; low target bits are ignored
    redirect_to(32'h0000_0100, 32'h0000_0100);
    redirect_to(32'h0000_0103, 32'h0000_0100);

    // Random traffic with occasional redirects
    for (int seg = 0; seg < 8; seg++) begin
      lat = $urandom_range(1, 4);
      p_rdy = $urandom_range(30, 100);
      p_dec = $urandom_range(30, 100);
      p_redir = 4;
      repeat (80) tick();
    end
    p_redir = 0;

    // Reset with requests in flight and the FIFO filling
    lat = 3;
    p_rdy = 100;
    p_dec = 0;
    repeat (6) tick();
    reset = 1'b1;
    repeat (2) tick();
    check_eq("rst_req", imem_req, 1'b0);
    check_eq("rst_addr", imem_addr, RST_PC);
    check_eq("rst_valid", instr_valid, 1'b0);
    check_eq("rst_instr", instr, 32'h0);
    check_eq("rst_instr_pc", instr_pc, 32'h0);
    reset = 1'b0;
    p_rdy = 0;
    p_dec = 100;
    for (int i = 0; i < 20 && mem_addr_q.size() > 0; i++) tick();
    tick();
    check_eq("late_rsp_ignored", instr_valid, 1'b0);
    p_rdy = 100;
    lat = 1;
    popped.delete();
    repeat (8) tick();
    check_eq("restart_len_ok", popped.size() >= 1, 1'b1);
    if (popped.size() >= 1) check_eq("restart_pc", popped[0], RST_PC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
